// File: rtl/jtag_dmi_master_if.sv
// DMI link bundle: TAP-side request/response plus the 4-phase DTM<->DM wires.
// master = the DTM-side initiator, slave = everything it talks to.
interface jtag_dmi_master_if #(
    parameter int unsigned REQ_BITS = 40
);
    logic                req_valid_i;
    logic                req_ready_o;
    logic [REQ_BITS-1:0] req_data_i;
    logic                resp_valid_o;
    logic                resp_ready_i;
    logic [REQ_BITS-1:0] resp_data_o;
    logic                dmi_reset_i;
    logic                sticky_err_o;
    logic                dtm_req_valid_o;
    logic [REQ_BITS-1:0] dtm_req_data_o;
    logic                dm_ack_i;
    logic                dm_resp_valid_i;
    logic [REQ_BITS-1:0] dm_resp_data_i;
    logic                dtm_ack_o;

    modport master (
        input  req_valid_i, req_data_i, resp_ready_i, dmi_reset_i,
        input  dm_ack_i, dm_resp_valid_i, dm_resp_data_i,
        output req_ready_o, resp_valid_o, resp_data_o, sticky_err_o,
        output dtm_req_valid_o, dtm_req_data_o, dtm_ack_o
    );

    modport slave (
        output req_valid_i, req_data_i, resp_ready_i, dmi_reset_i,
        output dm_ack_i, dm_resp_valid_i, dm_resp_data_i,
        input  req_ready_o, resp_valid_o, resp_data_o, sticky_err_o,
        input  dtm_req_valid_o, dtm_req_data_o, dtm_ack_o
    );
endinterface

// File: rtl/jtag_dmi_master.sv
// DTM-side DMI initiator: forwards one TAP request to the DM over a 4-phase
// req/ack link, returns the DM response, and owns timeout and sticky error.
module jtag_dmi_master #(
    parameter int unsigned DMI_ADDR_BITS  = 6,
    parameter int unsigned DMI_DATA_BITS  = 32,
    parameter int unsigned DMI_OP_BITS    = 2,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input logic                clk,
    input logic                rst,
    jtag_dmi_master_if.master  bus
);
    localparam int unsigned REQ_BITS = DMI_ADDR_BITS + DMI_DATA_BITS + DMI_OP_BITS;
    localparam int unsigned CNT_BITS = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DMI_OP_BITS-1:0] OP_FAILED = DMI_OP_BITS'(2'b10);
    localparam logic [DMI_OP_BITS-1:0] OP_BUSY   = DMI_OP_BITS'(2'b11);

    typedef enum logic [2:0] {
        IDLE, REQ_HI, REQ_LO, RSP_WAIT, RSP_ACK, RESP_OUT, ABORT
    } state_e;

    state_e                   state_q, state_d;
    logic [SYNC_STAGES-1:0]   ack_sync_q, rv_sync_q;
    logic                     ack_s, rv_s;
    logic [REQ_BITS-1:0]      req_q, req_d, resp_q, resp_d;
    logic                     req_vld_q, req_vld_d, ack_q, ack_d;
    logic                     sticky_q, sticky_d;
    logic                     ready_q, rvalid_q;
    logic [CNT_BITS-1:0]      cnt_q, cnt_d;
    logic                     waiting;

    assign ack_s = ack_sync_q[SYNC_STAGES-1];
    assign rv_s  = rv_sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        req_vld_d = req_vld_q;
        ack_d     = ack_q;
        resp_d    = resp_q;
        sticky_d  = sticky_q;
        waiting   = (state_q == REQ_HI) || (state_q == REQ_LO) ||
                    (state_q == RSP_WAIT) || (state_q == RSP_ACK);

        unique case (state_q)
            IDLE: if (bus.req_valid_i && ready_q) begin
                if (sticky_q) begin
                    resp_d  = {bus.req_data_i[REQ_BITS-1 -: DMI_ADDR_BITS],
                               {DMI_DATA_BITS{1'b0}}, OP_BUSY};
                    state_d = RESP_OUT;
                end else begin
                    req_d     = bus.req_data_i;
                    req_vld_d = 1'b1;
                    state_d   = REQ_HI;
                end
            end
            REQ_HI: if (ack_s) begin
                req_vld_d = 1'b0;
                state_d   = REQ_LO;
            end
            REQ_LO: if (!ack_s) state_d = RSP_WAIT;
            RSP_WAIT: if (rv_s) begin
                resp_d  = bus.dm_resp_data_i;
                ack_d   = 1'b1;
                state_d = RSP_ACK;
            end
            RSP_ACK: if (!rv_s) begin
                ack_d   = 1'b0;
                state_d = RESP_OUT;
            end
            RESP_OUT: if (bus.resp_ready_i) state_d = IDLE;
            ABORT: begin
                // Still complete any response handshake the DM started.
                ack_d = rv_s;
                if (!ack_s && !rv_s) begin
                    resp_d  = {req_q[REQ_BITS-1 -: DMI_ADDR_BITS],
                               {DMI_DATA_BITS{1'b0}}, OP_FAILED};
                    state_d = RESP_OUT;
                end
            end
            default: state_d = IDLE;
        endcase

        if (waiting && (cnt_q == CNT_BITS'(TIMEOUT_CYCLES))) begin
            sticky_d  = 1'b1;
            req_vld_d = 1'b0;
            ack_d     = 1'b0;
            state_d   = ABORT;
        end

        if (bus.dmi_reset_i) sticky_d = 1'b0;

        if (state_d != state_q) cnt_d = '0;
        else if (waiting)       cnt_d = cnt_q + 1'b1;
        else                    cnt_d = cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ack_sync_q <= '0;
            rv_sync_q  <= '0;
            req_q      <= '0;
            req_vld_q  <= 1'b0;
            ack_q      <= 1'b0;
            resp_q     <= '0;
            sticky_q   <= 1'b0;
            ready_q    <= 1'b0;
            rvalid_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], bus.dm_ack_i};
            rv_sync_q  <= {rv_sync_q[SYNC_STAGES-2:0], bus.dm_resp_valid_i};
            req_q      <= req_d;
            req_vld_q  <= req_vld_d;
            ack_q      <= ack_d;
            resp_q     <= resp_d;
            sticky_q   <= sticky_d;
            ready_q    <= (state_d == IDLE);
            rvalid_q   <= (state_d == RESP_OUT);
            cnt_q      <= cnt_d;
        end
    end

    assign bus.req_ready_o     = ready_q;
    assign bus.resp_valid_o    = rvalid_q;
    assign bus.resp_data_o     = resp_q;
    assign bus.sticky_err_o    = sticky_q;
    assign bus.dtm_req_valid_o = req_vld_q;
    assign bus.dtm_req_data_o  = req_q;
    assign bus.dtm_ack_o       = ack_q;
endmodule

// File: tb/tb_jtag_dmi_master.sv
// Directed bench for jtag_dmi_master with a behavioural DM stand-in and a
// transaction-level response model checked every cycle.
module tb_jtag_dmi_master;
    localparam int unsigned AB = 6;
    localparam int unsigned DB = 32;
    localparam int unsigned OB = 2;
    localparam int unsigned RB = AB + DB + OB;
    localparam int unsigned SS = 2;
    localparam int unsigned TO = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jtag_dmi_master_if #(.REQ_BITS(RB)) bus();

    jtag_dmi_master #(
        .DMI_ADDR_BITS(AB), .DMI_DATA_BITS(DB), .DMI_OP_BITS(OB),
        .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DM stand-in controls
    int              dm_dly  = 3;
    bit              dm_mute = 1'b0;
    logic [DB-1:0]   dm_rdata = '0;
    logic [RB-1:0]   dm_cap = '0;

    // Model state
    bit              m_sticky = 1'b0;
    logic [RB-1:0]   exp_resp = '0;
    bit              exp_valid = 1'b0;
    bit              forbid_req = 1'b0;
    int              pulse_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // What the TAP must see for a request, from the protocol rules alone.
    function automatic logic [RB-1:0] model_resp(input logic [RB-1:0] req, input bit sticky,
                                                 input bit mute, input logic [DB-1:0] rdata);
        logic [AB-1:0] a;
        logic [OB-1:0] op;
        a  = req[RB-1 -: AB];
        op = req[OB-1:0];
        if (sticky) return {a, {DB{1'b0}}, 2'b11};
        if (mute)   return {a, {DB{1'b0}}, 2'b10};
        return {a, (op == 2'b01) ? rdata : {DB{1'b0}}, 2'b00};
    endfunction

    // DM stand-in: full 4-phase slave with dm_dly cycles between phases.
    initial begin
        bus.dm_ack_i = 1'b0;
        bus.dm_resp_valid_i = 1'b0;
        bus.dm_resp_data_i = '0;
        forever begin
            @(posedge clk); #1;
            if (bus.dtm_req_valid_o && !dm_mute) begin
                dm_cap = bus.dtm_req_data_o;
                repeat (dm_dly) @(posedge clk);
                #1 bus.dm_ack_i = 1'b1;
                while (bus.dtm_req_valid_o) begin @(posedge clk); #1; end
                repeat (dm_dly) @(posedge clk);
                #1 bus.dm_ack_i = 1'b0;
                repeat (dm_dly) @(posedge clk);
                #1 bus.dm_resp_data_i = {dm_cap[RB-1 -: AB],
                                         (dm_cap[OB-1:0] == 2'b01) ? dm_rdata : {DB{1'b0}}, 2'b00};
                bus.dm_resp_valid_i = 1'b1;
                while (!bus.dtm_ack_o) begin @(posedge clk); #1; end
                repeat (dm_dly) @(posedge clk);
                #1 bus.dm_resp_valid_i = 1'b0;
                while (bus.dtm_ack_o) begin @(posedge clk); #1; end
            end
        end
    end

    // Per-cycle compare against the model and the link rules.
    logic          prev_v = 1'b0, prev_ack = 1'b0, prev_rv = 1'b0;
    logic [RB-1:0] prev_d = '0, prev_resp = '0;
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.resp_valid_o && exp_valid) chk("resp_data", bus.resp_data_o, exp_resp);
            if (bus.resp_valid_o) chk("ready_while_resp", bus.req_ready_o, 0);
            if (bus.resp_valid_o && prev_rv) chk("resp_stable", bus.resp_data_o, prev_resp);
            if (bus.dtm_req_valid_o && prev_v) chk("req_data_stable", bus.dtm_req_data_o, prev_d);
            if (forbid_req) chk("no_dtm_req", bus.dtm_req_valid_o, 0);
            if (prev_ack && bus.dm_resp_valid_i) chk("ack_hold", bus.dtm_ack_o, 1);
            if (bus.dtm_req_valid_o && !prev_v) pulse_cnt++;
        end
        prev_v    = bus.dtm_req_valid_o;
        prev_d    = bus.dtm_req_data_o;
        prev_ack  = bus.dtm_ack_o;
        prev_rv   = bus.resp_valid_o;
        prev_resp = bus.resp_data_o;
    end

    task automatic run_txn(input logic [RB-1:0] req, input int hold,
                           output int lat, output int pulses, output logic [RB-1:0] got);
        int n;
        int acc;
        int p0;
        exp_resp  = model_resp(req, m_sticky, dm_mute, dm_rdata);
        exp_valid = 1'b1;
        p0 = pulse_cnt;
        @(posedge clk); #1;
        bus.req_data_i  = req;
        bus.req_valid_i = 1'b1;
        n = 0;
        while (!bus.req_ready_o && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) chk("accept_timeout", 1, 0);
        @(posedge clk); #1;
        acc = cyc;
        bus.req_valid_i = 1'b0;
        n = 0;
        while (!bus.resp_valid_o && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) chk("resp_wait_timeout", 1, 0);
        lat = cyc - acc;
        got = bus.resp_data_o;
        if (hold > 0) begin
            forbid_req = 1'b1;
            bus.req_data_i  = {6'h2a, 32'h0, 2'b01};
            bus.req_valid_i = 1'b1;
            repeat (hold) begin
                @(posedge clk); #1;
                chk("ready_in_resp_out", bus.req_ready_o, 0);
                chk("resp_held_valid", bus.resp_valid_o, 1);
            end
            bus.req_valid_i = 1'b0;
            forbid_req = 1'b0;
        end
        bus.resp_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready_i = 1'b0;
        exp_valid = 1'b0;
        pulses = pulse_cnt - p0;
    endtask

    initial begin
        #300000;
        errors++;
        $display("FAIL watchdog: got no_finish expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        int lat;
        int pul;
        int n;
        logic [RB-1:0] got;

        bus.req_valid_i  = 1'b0;
        bus.req_data_i   = '0;
        bus.resp_ready_i = 1'b0;
        bus.dmi_reset_i  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", bus.req_ready_o, 0);
        chk("rst_resp_valid", bus.resp_valid_o, 0);
        chk("rst_dtm_req_valid", bus.dtm_req_valid_o, 0);
        chk("rst_dtm_ack", bus.dtm_ack_o, 0);
        chk("rst_sticky", bus.sticky_err_o, 0);
        chk("rst_resp_data", bus.resp_data_o, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_rst", bus.req_ready_o, 1);

        // 1: write
        dm_dly = 3;
        run_txn({6'h10, 32'h80000001, 2'b10}, 0, lat, pul, got);
        chk("t1_resp", got, {6'h10, 32'h0, 2'b00});
        chk("t1_pulses", pul, 1);
        chk("t1_dm_saw", dm_cap, {6'h10, 32'h80000001, 2'b10});
        chk("t1_min_latency", (lat >= 4 * (SS + 1)), 1);

        // 2: read
        dm_dly = 2;
        dm_rdata = 32'h00430c82;
        run_txn({6'h11, 32'h0, 2'b01}, 0, lat, pul, got);
        chk("t2_resp", got, {6'h11, 32'h00430c82, 2'b00});
        chk("t2_sticky", bus.sticky_err_o, 0);

        // 3: DM silent -> abort, then sticky rejects without forwarding
        dm_mute = 1'b1;
        run_txn({6'h13, 32'h0, 2'b01}, 0, lat, pul, got);
        chk("t3_resp", got, {6'h13, 32'h0, 2'b10});
        chk("t3_sticky", bus.sticky_err_o, 1);
        chk("t3_abort_latency", (lat >= TO && lat <= TO + 6), 1);
        m_sticky = 1'b1;
        dm_mute = 1'b0;
        forbid_req = 1'b1;
        run_txn({6'h12, 32'h12345678, 2'b01}, 0, lat, pul, got);
        forbid_req = 1'b0;
        chk("t3_busy_resp", got, {6'h12, 32'h0, 2'b11});
        chk("t3_busy_pulses", pul, 0);

        // 4: dmireset clears sticky, normal read
        bus.dmi_reset_i = 1'b1;
        @(posedge clk); #1;
        bus.dmi_reset_i = 1'b0;
        chk("t4_sticky_cleared", bus.sticky_err_o, 0);
        m_sticky = 1'b0;
        dm_rdata = 32'hdeadbeef;
        run_txn({6'h04, 32'h0, 2'b01}, 0, lat, pul, got);
        chk("t4_resp", got, {6'h04, 32'hdeadbeef, 2'b00});
        chk("t4_pulses", pul, 1);

        // 5: TAP stalls response for 20 cycles
        dm_rdata = 32'h0000cafe;
        run_txn({6'h20, 32'h0, 2'b01}, 20, lat, pul, got);
        chk("t5_resp", got, {6'h20, 32'h0000cafe, 2'b00});
        chk("t5_pulses", pul, 1);

        // unsupported op forwarded unchanged, answered as a NOP
        run_txn({6'h3f, 32'h00000005, 2'b11}, 0, lat, pul, got);
        chk("op11_resp", got, {6'h3f, 32'h0, 2'b00});
        chk("op11_forwarded", dm_cap, {6'h3f, 32'h00000005, 2'b11});

        // 6: reset while waiting for the DM response
        dm_dly = 6;
        @(posedge clk); #1;
        bus.req_data_i  = {6'h05, 32'h0, 2'b01};
        bus.req_valid_i = 1'b1;
        n = 0;
        while (!bus.req_ready_o && n < 100) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        n = 0;
        while (!bus.dm_ack_i && n < 100) begin @(negedge clk); n++; end
        while (bus.dm_ack_i && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) chk("t6_dm_handshake_timeout", 1, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("t6_pre_ack", bus.dtm_ack_o, 0);
        chk("t6_pre_resp_valid", bus.resp_valid_o, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t6_dtm_req_valid", bus.dtm_req_valid_o, 0);
        chk("t6_dtm_ack", bus.dtm_ack_o, 0);
        chk("t6_resp_valid", bus.resp_valid_o, 0);
        chk("t6_sticky", bus.sticky_err_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
